instr_mem_pipe: RTL and testbench

Parametrised, pipelined instruction memory for the fetch stage; the successor of the single-cycle combinational instruction ROM. Accepts fetch requests on a valid/ready handshake, returns instructions in order after a configurable read latency through an output buffer, flags out-of-range PCs, and supports flush and a boot-time load port for writing the program image.

---
 rtl/instr_mem_pkg.sv | 20 ++
 rtl/instr_resp_fifo.sv | 59 +++++
 rtl/instr_mem_pipe.sv | 122 ++++++++++++
 tb/tb_instr_mem_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared constants and helpers for the pipelined instruction memory.
// Covers the NOP encoding, the legal read latency range and the response buffer sizing.
package instr_mem_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;

    // Wide enough for any DATA_W in use; users truncate to their width.
    localparam logic [63:0] NOP_INSTR = 64'h0;

    function automatic bit latency_ok(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

    // One slot per pipeline stage plus one, so a full pipeline never stalls on a single pop.
    function automatic int cap_of(input int lat);
        return lat + 1;
    endfunction

endpackage

// File: rtl/instr_resp_fifo.sv
// Response buffer between the read pipeline and the fetch consumer.
// Output is forced to zero while empty, so an idle port shows all-zero fields.
module instr_resp_fifo
    import instr_mem_pkg::*;
#(
    parameter int WIDTH = 49,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_next(wr_ptr);
            if (do_rd) rd_ptr <= ptr_next(rd_ptr);
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (!do_wr && do_rd) count <= count - 1'b1;
        end
    end

    // NOTE: storage arrays carry no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_wr && !rst && !flush) store[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : store[rd_ptr];

endmodule

// File: rtl/instr_mem_pipe.sv
// Pipelined instruction memory for the fetch stage: valid/ready requests, in-order
// responses after LATENCY cycles, out-of-range fault flag, flush and a program load port.
module instr_mem_pipe
    import instr_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_pc,
    output logic              rsp_fault,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int CAP   = cap_of(LATENCY);
    localparam int CW    = $clog2(CAP + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RSP_W = DATA_W + ADDR_W + 1;
    localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INSTR);

    if (!latency_ok(LATENCY)) begin : g_bad_latency
        $error("instr_mem_pipe: LATENCY must be within 1..4");
    end

    typedef struct packed {
        logic              valid;
        logic              fault;
        logic [ADDR_W-1:0] pc;
    } stage_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     cnt;
    logic              accept;
    logic              pop;
    logic              ld_hit;
    stage_t            in_stg;
    stage_t            rd_stg;
    logic [DATA_W-1:0] rd_instr;
    logic [RSP_W-1:0]  fifo_din;
    logic [RSP_W-1:0]  fifo_dout;
    logic              fifo_empty;

    // Ready depends only on local state, never on rsp_ready.
    assign req_ready = !rst && !ld_en && !flush && (cnt < CW'(CAP));
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // NOTE: every field gets a value on every pass, so no latch is inferred.
    always_comb begin
        in_stg.valid = accept;
        in_stg.fault = (32'(req_pc) >= DEPTH);
        in_stg.pc    = req_pc;
    end

    // Outstanding count covers pipeline plus buffer, so the buffer can never overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + 1'b1;
        end else if (!accept && pop) begin
            cnt <= cnt - 1'b1;
        end
    end

    // The read stage feeds the buffer directly; LATENCY-1 registers sit in front of it.
    if (LATENCY == 1) begin : g_direct
        assign rd_stg = in_stg;
    end else begin : g_pipe
        stage_t pipe_q [LATENCY-1];

        always_ff @(posedge clk) begin
            for (int i = 0; i < LATENCY - 1; i++) begin
                pipe_q[i] <= (i == 0) ? in_stg : pipe_q[(i == 0) ? 0 : i - 1];
                if (rst || flush) pipe_q[i].valid <= 1'b0;
            end
        end

        assign rd_stg = pipe_q[LATENCY-2];
    end

    assign ld_hit = ld_en && (32'(ld_addr) < DEPTH);

    // NOTE: the program image survives reset, so the array is written without one.
    always_ff @(posedge clk) begin
        if (ld_hit) mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end

    // Reading at the last stage picks up any load committed at an earlier edge.
    assign rd_instr = rd_stg.fault ? NOP : mem[rd_stg.pc[IDX_W-1:0]];
    assign fifo_din = {rd_instr, rd_stg.pc, rd_stg.fault};

    instr_resp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (CAP)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (rd_stg.valid),
        .wr_data (fifo_din),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .empty   (fifo_empty)
    );

    assign rsp_valid                        = !fifo_empty;
    assign {rsp_instr, rsp_pc, rsp_fault}   = fifo_dout;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Scoreboard bench for instr_mem_pipe: one instance at LATENCY=2 and one at LATENCY=3
// share clock, reset, flush, load and PC; each has its own valid/ready and monitor.
module tb_instr_mem_pipe;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ld_en;
    logic [15:0] req_pc;
    logic [15:0] ld_addr;
    logic [31:0] ld_data;
    logic        req_valid [2];
    logic        rsp_ready [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_fault [2];
    logic [31:0] rsp_instr [2];
    logic [15:0] rsp_pc    [2];

    always #5 clk = ~clk;

    instr_mem_pipe #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_pc(req_pc),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr[0]),
        .rsp_pc(rsp_pc[0]), .rsp_fault(rsp_fault[0]), .flush(flush),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    instr_mem_pipe #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_pc(req_pc),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr[1]),
        .rsp_pc(rsp_pc[1]), .rsp_fault(rsp_fault[1]), .flush(flush),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    typedef struct {
        logic [31:0] instr;
        logic [15:0] pc;
        logic        fault;
        int          due;
    } exp_t;

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] img [DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          lat_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] pc, input int due);
        exp_t e;
        e.pc    = pc;
        e.fault = (32'(pc) >= DEPTH);
        e.instr = e.fault ? 32'h0 : img[pc[5:0]];
        e.due   = lat_chk ? due : -1;
        return e;
    endfunction

    // Drives one request cycle on instance d; the expectation is queued only if accepted.
    task automatic issue(input int d, input logic [15:0] pc, output bit acc);
        exp_t e;
        req_valid[1-d] = 1'b0;
        req_valid[d]   = 1'b1;
        req_pc         = pc;
        @(negedge clk);
        acc = req_ready[d];
        if (acc) begin
            e = mk(pc, cyc + ((d == 0) ? 2 : 3));
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
    endtask

    task automatic load(input logic [15:0] a, input logic [31:0] dat);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = dat;
        if (32'(a) < DEPTH) img[a[5:0]] = dat;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic cmp(input int d, input exp_t e);
        check($sformatf("d%0d rsp_instr pc=%0d", d, e.pc), 64'(rsp_instr[d]), 64'(e.instr));
        check($sformatf("d%0d rsp_pc", d), 64'(rsp_pc[d]), 64'(e.pc));
        check($sformatf("d%0d rsp_fault pc=%0d", d, e.pc), 64'(rsp_fault[d]), 64'(e.fault));
        if (e.due >= 0 && rsp_ready[d])
            check($sformatf("d%0d latency pc=%0d", d, e.pc), 64'(cyc), 64'(e.due));
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid[0]) begin
            if (q0.size() == 0) check("d0 stray rsp_valid", 64'(rsp_valid[0]), 64'h0);
            else begin
                cmp(0, q0[0]);
                if (rsp_ready[0]) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid[1]) begin
            if (q1.size() == 0) check("d1 stray rsp_valid", 64'(rsp_valid[1]), 64'h0);
            else begin
                cmp(1, q1[0]);
                if (rsp_ready[1]) void'(q1.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n_acc;
        rst = 1'b1; flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; req_pc = '0;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d req_ready in reset", d), 64'(req_ready[d]), 64'h0);
            check($sformatf("d%0d rsp_valid in reset", d), 64'(rsp_valid[d]), 64'h0);
            check($sformatf("d%0d rsp_instr in reset", d), 64'(rsp_instr[d]), 64'h0);
            check($sformatf("d%0d rsp_pc in reset", d), 64'(rsp_pc[d]), 64'h0);
            check($sformatf("d%0d rsp_fault in reset", d), 64'(rsp_fault[d]), 64'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("d0 req_ready after reset", 64'(req_ready[0]), 64'h1);
        check("d1 req_ready after reset", 64'(req_ready[1]), 64'h1);
        @(posedge clk); #1;

        // Program image: word k = k + 0x100
        for (int k = 0; k < DEPTH; k++) load(16'(k), 32'h100 + 32'(k));

        // Back-to-back fetches with fixed latency
        lat_chk = 1'b1;
        issue(0, 16'd0, acc); issue(0, 16'd1, acc); issue(0, 16'd2, acc);
        idle();
        repeat (5) @(posedge clk); #1;
        issue(1, 16'd10, acc); issue(1, 16'd11, acc);
        idle();
        repeat (5) @(posedge clk); #1;

        // Out-of-range PC then a normal one
        issue(0, 16'd64, acc); issue(0, 16'd5, acc);
        idle();
        repeat (5) @(posedge clk); #1;

        // Load blocks requests in its cycle; the next cycle sees the new word
        ld_en = 1'b1; ld_addr = 16'd7; ld_data = 32'hDEADBEEF; img[7] = 32'hDEADBEEF;
        req_valid[0] = 1'b1; req_pc = 16'd3;
        @(negedge clk);
        check("d0 req_ready during load", 64'(req_ready[0]), 64'h0);
        check("d1 req_ready during load", 64'(req_ready[1]), 64'h0);
        @(posedge clk); #1;
        ld_en = 1'b0;
        issue(0, 16'd7, acc);
        check("d0 accept after load", 64'(acc), 64'h1);
        idle();
        load(16'd71, 32'h0BAD0BAD);
        issue(0, 16'd7, acc); issue(1, 16'd7, acc);
        idle();
        repeat (6) @(posedge clk); #1;

        // Backpressure on LATENCY=3: exactly four accepted
        lat_chk = 1'b0;
        rsp_ready[1] = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            issue(1, 16'(20 + i), acc);
            n_acc += int'(acc);
        end
        idle();
        check("d1 accepted under backpressure", 64'(n_acc), 64'd4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("d1 req_ready when full", 64'(req_ready[1]), 64'h0);
        @(posedge clk); #1;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("d1 req_ready before first pop", 64'(req_ready[1]), 64'h0);
        @(negedge clk);
        check("d1 req_ready after first pop", 64'(req_ready[1]), 64'h1);
        repeat (8) @(posedge clk); #1;

        // Flush with three requests in flight
        rsp_ready[1] = 1'b0;
        issue(1, 16'd30, acc); issue(1, 16'd31, acc); issue(1, 16'd32, acc);
        idle();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        q0.delete(); q1.delete();
        @(negedge clk);
        check("d1 rsp_valid after flush", 64'(rsp_valid[1]), 64'h0);
        check("d1 req_ready after flush", 64'(req_ready[1]), 64'h1);
        rsp_ready[1] = 1'b1;
        repeat (8) @(posedge clk); #1;
        lat_chk = 1'b1;
        issue(1, 16'd5, acc);
        idle();
        repeat (6) @(posedge clk); #1;

        // Reset with three requests in flight; memory contents survive
        lat_chk = 1'b0;
        rsp_ready[0] = 1'b0;
        issue(0, 16'd40, acc); issue(0, 16'd41, acc); issue(0, 16'd42, acc);
        idle();
        rst = 1'b1;
        @(negedge clk);
        check("d0 req_ready during mid reset", 64'(req_ready[0]), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete(); q1.delete();
        @(negedge clk);
        check("d0 rsp_valid after mid reset", 64'(rsp_valid[0]), 64'h0);
        check("d0 rsp_instr after mid reset", 64'(rsp_instr[0]), 64'h0);
        check("d0 req_ready after mid reset", 64'(req_ready[0]), 64'h1);
        rsp_ready[0] = 1'b1;
        repeat (8) @(posedge clk); #1;
        lat_chk = 1'b1;
        issue(0, 16'd7, acc);
        idle();
        repeat (6) @(posedge clk); #1;

        check("d0 responses outstanding", 64'(q0.size()), 64'h0);
        check("d1 responses outstanding", 64'(q1.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
